// File: rtl/xgmii_tx_scheduler.sv
// Round-robin frame scheduler for a 64-bit XGMII-style transmit lane: start/preamble,
// payload pass-through, terminate insertion and IPG. Optional counters under XGMII_TX_STATS_EN.
module xgmii_tx_scheduler #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 64,
   parameter int IPG_WORDS  = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   input  logic [NUM_REQ*4-1:0]            req_keep,
   input  logic [NUM_REQ-1:0]              req_last,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [DATA_WIDTH-1:0]           data_out,
   output logic [7:0]                      ctrl_out,
   output logic [NUM_REQ-1:0]              grant
`ifdef XGMII_TX_STATS_EN
   ,
   output logic [31:0]                     frame_cnt,
   output logic [15:0]                     underrun_cnt
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_TERM, S_IPG} state_t;

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [63:0] IDLE_W  = {8{8'h07}};
   localparam logic [63:0] START_W = 64'hD5555555555555FB;
   localparam logic [63:0] ERR_W   = {8{8'hFE}};
   localparam logic [63:0] TERM_W  = 64'h07070707070707FD;

   state_t               r_state, w_state_nxt;
   logic [PTR_W-1:0]     r_rr_ptr, r_gidx, w_win, w_idx, w_ptr_nxt;
   logic                 w_found;
   logic [NUM_REQ-1:0]   r_grant;
   logic [4:0]           r_ipg_cnt;
   logic                 w_ipg_done;
   logic [63:0]          r_data, w_data;
   logic [7:0]           r_ctrl, w_ctrl;
   logic                 w_sel_valid, w_sel_last;
   logic [63:0]          w_sel_data;
   logic [3:0]           w_sel_keep, w_keep_n;
   logic                 w_term, w_underrun;

   // First valid requester at or after the round-robin pointer.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
      w_ptr_nxt = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
   end

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = '0;
      w_sel_keep  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_gidx == PTR_W'(i)) begin
            w_sel_valid = req_valid[i];
            w_sel_last  = req_last[i];
            w_sel_data  = req_data[DATA_WIDTH*i +: 64];
            w_sel_keep  = req_keep[4*i +: 4];
         end
      end
      w_keep_n = (w_sel_keep == 4'd0 || w_sel_keep > 4'd8) ? 4'd8 : w_sel_keep;
   end

   assign w_ipg_done = (int'(r_ipg_cnt) + 1 >= IPG_WORDS);

   always_comb begin
      w_state_nxt = r_state;
      w_data      = IDLE_W;
      w_ctrl      = 8'hFF;
      w_term      = 1'b0;
      w_underrun  = 1'b0;
      case (r_state)
         S_IDLE: if (w_found) w_state_nxt = S_START;
         S_START: begin
            w_data      = START_W;
            w_ctrl      = 8'h01;
            w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (!w_sel_valid) begin
               w_data     = ERR_W;
               w_ctrl     = 8'hFF;
               w_underrun = 1'b1;
            end else begin
               w_data = w_sel_data;
               w_ctrl = 8'h00;
               if (w_sel_last) begin
                  if (w_keep_n == 4'd8) begin
                     w_state_nxt = S_TERM;
                  end else begin
                     // Terminate lands in the first unused lane; lanes above pad with idle.
                     for (int j = 0; j < 8; j++) begin
                        if (j == int'(w_keep_n)) begin
                           w_data[8*j +: 8] = 8'hFD;
                           w_ctrl[j]        = 1'b1;
                        end else if (j > int'(w_keep_n)) begin
                           w_data[8*j +: 8] = 8'h07;
                           w_ctrl[j]        = 1'b1;
                        end
                     end
                     w_term      = 1'b1;
                     w_state_nxt = S_IPG;
                  end
               end
            end
         end
         S_TERM: begin
            w_data      = TERM_W;
            w_ctrl      = 8'hFF;
            w_term      = 1'b1;
            w_state_nxt = S_IPG;
         end
         S_IPG: if (w_ipg_done) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= '0;
         r_gidx    <= '0;
         r_grant   <= '0;
         r_ipg_cnt <= '0;
         r_data    <= IDLE_W;
         r_ctrl    <= 8'hFF;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data;
         r_ctrl  <= w_ctrl;
         if (r_state == S_IDLE && w_found) begin
            r_gidx   <= w_win;
            r_grant  <= NUM_REQ'(1) << w_win;
            r_rr_ptr <= w_ptr_nxt;
         end
         if (w_state_nxt == S_IPG && r_state != S_IPG) r_grant <= '0;
         if (r_state == S_IPG) r_ipg_cnt <= r_ipg_cnt + 5'd1;
         else                  r_ipg_cnt <= '0;
      end
   end

`ifdef XGMII_TX_STATS_EN
   logic [31:0] r_frame_cnt;
   logic [15:0] r_underrun_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt    <= '0;
         r_underrun_cnt <= '0;
      end else begin
         if (w_term) r_frame_cnt <= r_frame_cnt + 32'd1;
         if (w_underrun && r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
   end

   assign frame_cnt    = r_frame_cnt;
   assign underrun_cnt = r_underrun_cnt;
`endif

   assign req_ready = (r_state == S_DATA) ? r_grant : '0;
   assign grant     = r_grant;
   assign data_out  = r_data;
   assign ctrl_out  = r_ctrl;

endmodule

// File: tb/tb_xgmii_tx_scheduler.sv
// Directed bench for xgmii_tx_scheduler (NUM_REQ=2, IPG_WORDS=1); counter checks
// are compiled in only when XGMII_TX_STATS_EN is defined.
module tb_xgmii_tx_scheduler;

   localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
   localparam logic [63:0] START_W = 64'hD5555555555555FB;
   localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;
   localparam logic [63:0] TERM_W  = 64'h07070707070707FD;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   req_valid = '0;
   logic [127:0] req_data = '0;
   logic [7:0]   req_keep = '0;
   logic [1:0]   req_last = '0;
   logic [1:0]   req_ready;
   logic [63:0]  data_out;
   logic [7:0]   ctrl_out;
   logic [1:0]   grant;
`ifdef XGMII_TX_STATS_EN
   logic [31:0]  frame_cnt;
   logic [15:0]  underrun_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   xgmii_tx_scheduler #(.NUM_REQ(2), .DATA_WIDTH(64), .IPG_WORDS(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep), .req_last(req_last),
      .req_ready(req_ready), .data_out(data_out), .ctrl_out(ctrl_out), .grant(grant)
`ifdef XGMII_TX_STATS_EN
      , .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int s, input logic v, input logic [63:0] d, input logic [3:0] k, input logic l);
      req_valid[s]        = v;
      req_data[64*s +: 64] = d;
      req_keep[4*s +: 4]   = k;
      req_last[s]          = l;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (data_out !== IDLE_W || ctrl_out !== 8'hFF) begin errors++; $display("FAIL reset_word: got %h/%h want %h/ff", data_out, ctrl_out, IDLE_W); end
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
`ifdef XGMII_TX_STATS_EN
      checks++; if (frame_cnt !== 32'd0 || underrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", frame_cnt, underrun_cnt); end
`endif
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_single_frame;
      drive(0, 1'b1, 64'h0123456789ABCDEF, 4'd0, 1'b0);
      tick;
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL sf_grant: got %b want 01", grant); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL sf_ready_start: got %b want 00", req_ready); end
      tick;
      checks++; if (data_out !== START_W || ctrl_out !== 8'h01) begin errors++; $display("FAIL sf_start: got %h/%h want %h/01", data_out, ctrl_out, START_W); end
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL sf_ready_data: got %b want 01", req_ready); end
      tick;
      checks++; if (data_out !== 64'h0123456789ABCDEF || ctrl_out !== 8'h00) begin errors++; $display("FAIL sf_d0: got %h/%h want 0123456789abcdef/00", data_out, ctrl_out); end
      drive(0, 1'b1, 64'hFEDCBA9876543210, 4'd0, 1'b0);
      tick;
      checks++; if (data_out !== 64'hFEDCBA9876543210 || ctrl_out !== 8'h00) begin errors++; $display("FAIL sf_d1: got %h/%h want fedcba9876543210/00", data_out, ctrl_out); end
      drive(0, 1'b1, 64'h1111111111CCBBAA, 4'd3, 1'b1);
      tick;
      checks++; if (data_out !== 64'h07070707FDCCBBAA || ctrl_out !== 8'hF8) begin errors++; $display("FAIL sf_term: got %h/%h want 07070707fdccbbaa/f8", data_out, ctrl_out); end
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sf_grant_clr: got %b want 00", grant); end
      drive(0, 1'b0, 64'h0, 4'd0, 1'b0);
      tick;
      checks++; if (data_out !== IDLE_W || ctrl_out !== 8'hFF) begin errors++; $display("FAIL sf_ipg: got %h/%h want idle/ff", data_out, ctrl_out); end
      tick;
      checks++; if (data_out !== IDLE_W || ctrl_out !== 8'hFF) begin errors++; $display("FAIL sf_idle: got %h/%h want idle/ff", data_out, ctrl_out); end
   endtask

   task automatic test_keep8;
      drive(1, 1'b1, 64'h8877665544332211, 4'd8, 1'b1);
      tick;
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL k8_grant: got %b want 10", grant); end
      tick;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL k8_ready: got %b want 10", req_ready); end
      tick;
      checks++; if (data_out !== 64'h8877665544332211 || ctrl_out !== 8'h00) begin errors++; $display("FAIL k8_data: got %h/%h want 8877665544332211/00", data_out, ctrl_out); end
      drive(1, 1'b0, 64'h0, 4'd0, 1'b0);
      tick;
      checks++; if (data_out !== TERM_W || ctrl_out !== 8'hFF) begin errors++; $display("FAIL k8_term: got %h/%h want %h/ff", data_out, ctrl_out, TERM_W); end
      tick;
      checks++; if (data_out !== IDLE_W || ctrl_out !== 8'hFF) begin errors++; $display("FAIL k8_ipg: got %h/%h want idle/ff", data_out, ctrl_out); end
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL k8_grant_clr: got %b want 00", grant); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] exp_term [2];
      logic [1:0]  exp_g;
      exp_term[0] = 64'h070707FDA3A2A1A0;
      exp_term[1] = 64'h070707FDB3B2B1B0;
      drive(0, 1'b1, 64'hDEADBEEFA3A2A1A0, 4'd4, 1'b1);
      drive(1, 1'b1, 64'hCAFEF00DB3B2B1B0, 4'd4, 1'b1);
      for (int f = 0; f < 4; f++) begin
         exp_g = (f % 2 == 0) ? 2'b01 : 2'b10;
         tick;
         checks++; if (grant !== exp_g) begin errors++; $display("FAIL b2b_grant[%0d]: got %b want %b", f, grant, exp_g); end
         checks++; if (data_out !== IDLE_W) begin errors++; $display("FAIL b2b_arb_idle[%0d]: got %h want idle", f, data_out); end
         tick;
         checks++; if (data_out !== START_W || req_ready !== exp_g) begin errors++; $display("FAIL b2b_start[%0d]: got %h rdy %b want start rdy %b", f, data_out, req_ready, exp_g); end
         tick;
         checks++; if (data_out !== exp_term[f%2] || ctrl_out !== 8'hF0) begin errors++; $display("FAIL b2b_term[%0d]: got %h/%h want %h/f0", f, data_out, ctrl_out, exp_term[f%2]); end
         tick;
         checks++; if (data_out !== IDLE_W || ctrl_out !== 8'hFF) begin errors++; $display("FAIL b2b_ipg[%0d]: got %h/%h want idle/ff", f, data_out, ctrl_out); end
      end
      drive(0, 1'b0, 64'h0, 4'd0, 1'b0);
      drive(1, 1'b0, 64'h0, 4'd0, 1'b0);
      tick;
   endtask

   task automatic test_underrun;
`ifdef XGMII_TX_STATS_EN
      logic [31:0] f0;
      logic [15:0] u0;
      f0 = frame_cnt;
      u0 = underrun_cnt;
`endif
      drive(0, 1'b1, 64'h1111111111111111, 4'd0, 1'b0);
      tick;
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ur_grant: got %b want 01", grant); end
      tick;
      tick;
      checks++; if (data_out !== 64'h1111111111111111 || ctrl_out !== 8'h00) begin errors++; $display("FAIL ur_d0: got %h/%h want 1111111111111111/00", data_out, ctrl_out); end
      drive(0, 1'b0, 64'h0, 4'd0, 1'b0);
      tick;
      checks++; if (data_out !== ERR_W || ctrl_out !== 8'hFF) begin errors++; $display("FAIL ur_err0: got %h/%h want %h/ff", data_out, ctrl_out, ERR_W); end
      tick;
      checks++; if (data_out !== ERR_W || ctrl_out !== 8'hFF) begin errors++; $display("FAIL ur_err1: got %h/%h want %h/ff", data_out, ctrl_out, ERR_W); end
      drive(0, 1'b1, 64'h999999999999C1C0, 4'd2, 1'b1);
      tick;
      checks++; if (data_out !== 64'h0707070707FDC1C0 || ctrl_out !== 8'hFC) begin errors++; $display("FAIL ur_term: got %h/%h want 0707070707fdc1c0/fc", data_out, ctrl_out); end
      drive(0, 1'b0, 64'h0, 4'd0, 1'b0);
      tick;
      checks++; if (data_out !== IDLE_W) begin errors++; $display("FAIL ur_ipg: got %h want idle", data_out); end
`ifdef XGMII_TX_STATS_EN
      checks++; if (underrun_cnt !== u0 + 16'd2) begin errors++; $display("FAIL ur_cnt: got %0d want %0d", underrun_cnt, u0 + 16'd2); end
      checks++; if (frame_cnt !== f0 + 32'd1) begin errors++; $display("FAIL ur_frames: got %0d want %0d", frame_cnt, f0 + 32'd1); end
`endif
      tick;
   endtask

   task automatic test_reset_mid_frame;
      // Pointer is at 1 here; granting source 0 leaves it at 1 so a post-reset grant of 0 shows the pointer cleared.
      drive(0, 1'b1, 64'h5555AAAA5555AAAA, 4'd0, 1'b0);
      tick;
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rm_grant_pre: got %b want 01", grant); end
      tick;
      tick;
      checks++; if (data_out !== 64'h5555AAAA5555AAAA) begin errors++; $display("FAIL rm_d0: got %h want 5555aaaa5555aaaa", data_out); end
      rst_n = 1'b0;
      #1;
      checks++; if (data_out !== IDLE_W || ctrl_out !== 8'hFF) begin errors++; $display("FAIL rm_async_word: got %h/%h want idle/ff", data_out, ctrl_out); end
      checks++; if (grant !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL rm_async_ctl: got grant %b rdy %b want 00/00", grant, req_ready); end
      drive(0, 1'b0, 64'h0, 4'd0, 1'b0);
      tick;
      rst_n = 1'b1;
      drive(0, 1'b1, 64'h0F0E0D0C0B0A0908, 4'd8, 1'b1);
      drive(1, 1'b1, 64'h1F1E1D1C1B1A1918, 4'd8, 1'b1);
      tick;
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rm_grant_post: got %b want 01", grant); end
      tick;
      checks++; if (data_out !== START_W || ctrl_out !== 8'h01) begin errors++; $display("FAIL rm_start: got %h/%h want %h/01", data_out, ctrl_out, START_W); end
      tick;
      checks++; if (data_out !== 64'h0F0E0D0C0B0A0908 || ctrl_out !== 8'h00) begin errors++; $display("FAIL rm_data: got %h/%h want 0f0e0d0c0b0a0908/00", data_out, ctrl_out); end
      drive(0, 1'b0, 64'h0, 4'd0, 1'b0);
      drive(1, 1'b0, 64'h0, 4'd0, 1'b0);
      tick;
      checks++; if (data_out !== TERM_W || ctrl_out !== 8'hFF) begin errors++; $display("FAIL rm_term: got %h/%h want %h/ff", data_out, ctrl_out, TERM_W); end
      tick;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_single_frame;
      test_keep8;
      test_back_to_back;
      test_underrun;
      test_reset_mid_frame;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
